command_word_sequencer: RTL and testbench

Bus-side front end of the 8259A control logic. It detects completed CPU write cycles (chip_select_n, write_enable_n, A0, D[7:0]), latches the written byte onto internal_data_bus and steps the ICW1→ICW2→[ICW3]→[ICW4]→ready initialization sequence. It then decodes OCW1/2/3 writes. Its one-cycle write strobes directly drive the ICW1 configuration register and the ICW2–4/OCW register stages downstream.

---
 rtl/command_word_sequencer_pkg.sv | 26 ++
 rtl/command_word_sequencer_if.sv | 22 ++
 rtl/command_word_sequencer_bus_write_detector.sv | 47 ++++
 rtl/command_word_sequencer.sv | 121 ++++++++++++
 tb/tb_command_word_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/command_word_sequencer_pkg.sv
// Shared constants for the 8259A command word front end.
// State encoding and command byte bit positions.
package pic_pkg;

    localparam logic [2:0] ST_WAIT_ICW1 = 3'd0;
    localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;

    localparam int ICW1_SEL_BIT  = 4;
    localparam int OCW3_SEL_BIT  = 3;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_IC4_BIT  = 0;

    typedef struct packed {
        logic icw1;
        logic icw2;
        logic icw3;
        logic icw4;
        logic ocw1;
        logic ocw2;
        logic ocw3;
    } strobe_t;

endpackage

// File: rtl/command_word_sequencer_if.sv
// CPU-side write bus of the command word sequencer.
// The CPU drives it; the sequencer only observes it.
interface command_word_sequencer_if;
    logic       chip_select_n;
    logic       write_enable_n;
    logic       address;
    logic [7:0] data_bus_in;

    modport master (
        output chip_select_n,
        output write_enable_n,
        output address,
        output data_bus_in
    );

    modport slave (
        input chip_select_n,
        input write_enable_n,
        input address,
        input data_bus_in
    );
endinterface

// File: rtl/command_word_sequencer_bus_write_detector.sv
// Synchronizes the CPU write strobes and flags completed write cycles.
// The last write-low sample of a low phase supplies A0 and data.
module bus_write_detector (
    input  logic                            clock,
    input  logic                            reset,
    command_word_sequencer_if.slave         bus,
    output logic                            accept,
    output logic                            captured_a0,
    output logic [7:0]                      captured_data
);

    logic wr_s1;
    logic wr_s2;
    logic cs_s1;
    logic cs_s2;
    logic armed;
    logic write_low;

    assign write_low = !wr_s2 && !cs_s2;
    // armed survives CS_n rising early so the WR_n rise still completes
    assign accept    = wr_s2 && armed;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_s1         <= 1'b1;
            wr_s2         <= 1'b1;
            cs_s1         <= 1'b1;
            cs_s2         <= 1'b1;
            armed         <= 1'b0;
            captured_a0   <= 1'b0;
            captured_data <= 8'h00;
        end else begin
            wr_s1 <= bus.write_enable_n;
            wr_s2 <= wr_s1;
            cs_s1 <= bus.chip_select_n;
            cs_s2 <= cs_s1;
            if (write_low) begin
                armed         <= 1'b1;
                captured_a0   <= bus.address;
                captured_data <= bus.data_bus_in;
            end else if (wr_s2) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/command_word_sequencer.sv
// ICW/OCW sequencer: steps the 8259A initialization sequence and
// decodes operation control words into one-cycle write strobes.
module command_word_sequencer
    import pic_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    command_word_sequencer_if.slave bus,
    output logic [7:0]              internal_data_bus,
    output logic                    write_initial_command_word_1,
    output logic                    write_initial_command_word_2,
    output logic                    write_initial_command_word_3,
    output logic                    write_initial_command_word_4,
    output logic                    write_operation_control_word_1,
    output logic                    write_operation_control_word_2,
    output logic                    write_operation_control_word_3,
    output logic                    initialization_done,
    output logic [2:0]              init_state
);

    logic       accept;
    logic       a0;
    logic [7:0] data;

    bus_write_detector u_detector (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .accept        (accept),
        .captured_a0   (a0),
        .captured_data (data)
    );

    logic [2:0] state;
    logic [2:0] nxt_state;
    logic       sngl;
    logic       nxt_sngl;
    logic       ic4;
    logic       nxt_ic4;
    strobe_t    stb_q;
    strobe_t    nxt_stb;
    logic       is_icw1;
    logic       is_ocw;
    logic       in_ready;

    assign is_icw1  = !a0 && data[ICW1_SEL_BIT];
    assign is_ocw   = !a0 && !data[ICW1_SEL_BIT];
    assign in_ready = state == ST_READY;

    // ICW1 outranks everything and restarts the sequence from any state
    always_comb begin
        nxt_state = state;
        nxt_sngl  = sngl;
        nxt_ic4   = ic4;
        nxt_stb   = '0;
        if (accept) begin
            unique case (1'b1)
                is_icw1: begin
                    nxt_stb.icw1 = 1'b1;
                    nxt_sngl     = data[ICW1_SNGL_BIT];
                    nxt_ic4      = data[ICW1_IC4_BIT];
                    nxt_state    = ST_WAIT_ICW2;
                end
                a0 && state == ST_WAIT_ICW2: begin
                    nxt_stb.icw2 = 1'b1;
                    nxt_state    = !sngl ? ST_WAIT_ICW3 :
                                   ic4   ? ST_WAIT_ICW4 : ST_READY;
                end
                a0 && state == ST_WAIT_ICW3: begin
                    nxt_stb.icw3 = 1'b1;
                    nxt_state    = ic4 ? ST_WAIT_ICW4 : ST_READY;
                end
                a0 && state == ST_WAIT_ICW4: begin
                    nxt_stb.icw4 = 1'b1;
                    nxt_state    = ST_READY;
                end
                a0 && in_ready: begin
                    nxt_stb.ocw1 = 1'b1;
                end
                is_ocw && in_ready && !data[OCW3_SEL_BIT]: begin
                    nxt_stb.ocw2 = 1'b1;
                end
                is_ocw && in_ready && data[OCW3_SEL_BIT]: begin
                    nxt_stb.ocw3 = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= ST_WAIT_ICW1;
            sngl                <= 1'b1;
            ic4                 <= 1'b0;
            stb_q               <= '0;
            internal_data_bus   <= 8'h00;
            initialization_done <= 1'b0;
        end else begin
            state               <= nxt_state;
            sngl                <= nxt_sngl;
            ic4                 <= nxt_ic4;
            stb_q               <= nxt_stb;
            initialization_done <= nxt_state == ST_READY;
            if (|nxt_stb) begin
                internal_data_bus <= data;
            end
        end
    end

    assign init_state                     = state;
    assign write_initial_command_word_1   = stb_q.icw1;
    assign write_initial_command_word_2   = stb_q.icw2;
    assign write_initial_command_word_3   = stb_q.icw3;
    assign write_initial_command_word_4   = stb_q.icw4;
    assign write_operation_control_word_1 = stb_q.ocw1;
    assign write_operation_control_word_2 = stb_q.ocw2;
    assign write_operation_control_word_3 = stb_q.ocw3;

endmodule

// File: tb/tb_command_word_sequencer.sv
// Directed-vector bench for command_word_sequencer.
// Strobes are sampled 1 time unit after each rising edge.
module tb_command_word_sequencer;

    logic       clock;
    logic       reset;
    logic [7:0] internal_data_bus;
    logic       icw1, icw2, icw3, icw4;
    logic       ocw1, ocw2, ocw3;
    logic       initialization_done;
    logic [2:0] init_state;

    command_word_sequencer_if bus ();

    command_word_sequencer dut (
        .clock                          (clock),
        .reset                          (reset),
        .bus                            (bus),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (icw1),
        .write_initial_command_word_2   (icw2),
        .write_initial_command_word_3   (icw3),
        .write_initial_command_word_4   (icw4),
        .write_operation_control_word_1 (ocw1),
        .write_operation_control_word_2 (ocw2),
        .write_operation_control_word_3 (ocw3),
        .initialization_done            (initialization_done),
        .init_state                     (init_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_ICW1 = 7'b1000000;
    localparam logic [6:0] S_ICW2 = 7'b0100000;
    localparam logic [6:0] S_ICW3 = 7'b0010000;
    localparam logic [6:0] S_ICW4 = 7'b0001000;
    localparam logic [6:0] S_OCW1 = 7'b0000100;
    localparam logic [6:0] S_OCW2 = 7'b0000010;
    localparam logic [6:0] S_OCW3 = 7'b0000001;

    logic [6:0] stb;
    assign stb = {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3};

    int checks = 0;
    int errors = 0;

    // strobes and done observed after edges 1..4 following the WR_n rise
    logic [6:0] seen [1:4];
    logic       done_at [1:4];
    logic [27:0] seq;
    logic [27:0] exp_seq;

    task automatic drive_low(input logic a0, input logic [7:0] d,
                             input logic sel);
        @(negedge clock);
        bus.address        = a0;
        bus.data_bus_in    = d;
        bus.chip_select_n  = !sel;
        bus.write_enable_n = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic release_watch();
        bus.write_enable_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clock);
            #1;
            seen[e]    = stb;
            done_at[e] = initialization_done;
        end
        seq = {seen[1], seen[2], seen[3], seen[4]};
        @(negedge clock);
        bus.chip_select_n = 1'b1;
    endtask

    task automatic do_write(input logic a0, input logic [7:0] d,
                            input logic sel);
        drive_low(a0, d, sel);
        release_watch();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({stb, init_state, initialization_done, internal_data_bus}
            !== {S_NONE, 3'd0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got stb=%b st=%0d done=%b bus=%h want 0/0/0/00",
                     stb, init_state, initialization_done, internal_data_bus);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single_icw4();
        do_write(1'b0, 8'h13, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW1, S_NONE};
        checks++;
        if (seq !== exp_seq || internal_data_bus !== 8'h13 || init_state !== 3'd1) begin
            errors++;
            $display("FAIL single_icw1 got seq=%h bus=%h st=%0d want %h 13 1",
                     seq, internal_data_bus, init_state, exp_seq);
        end
        do_write(1'b1, 8'h40, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW2, S_NONE};
        checks++;
        if (seq !== exp_seq || internal_data_bus !== 8'h40 ||
            init_state !== 3'd3 || initialization_done !== 1'b0) begin
            errors++;
            $display("FAIL single_icw2 got seq=%h bus=%h st=%0d done=%b want %h 40 3 0",
                     seq, internal_data_bus, init_state, initialization_done, exp_seq);
        end
        do_write(1'b1, 8'h02, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW4, S_NONE};
        checks++;
        if (seq !== exp_seq || init_state !== 3'd4 ||
            {done_at[2], done_at[3]} !== 2'b01) begin
            errors++;
            $display("FAIL single_icw4 got seq=%h st=%0d done23=%b%b want %h 4 01",
                     seq, init_state, done_at[2], done_at[3], exp_seq);
        end
    endtask

    task automatic test_cascade();
        do_write(1'b0, 8'h11, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW1, S_NONE};
        checks++;
        if (seq !== exp_seq || init_state !== 3'd1 || initialization_done !== 1'b0) begin
            errors++;
            $display("FAIL casc_icw1 got seq=%h st=%0d done=%b want %h 1 0",
                     seq, init_state, initialization_done, exp_seq);
        end
        do_write(1'b1, 8'h20, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW2, S_NONE};
        checks++;
        if (seq !== exp_seq || init_state !== 3'd2) begin
            errors++;
            $display("FAIL casc_icw2 got seq=%h st=%0d want %h 2", seq, init_state, exp_seq);
        end
        do_write(1'b1, 8'h04, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW3, S_NONE};
        checks++;
        if (seq !== exp_seq || init_state !== 3'd3 || internal_data_bus !== 8'h04) begin
            errors++;
            $display("FAIL casc_icw3 got seq=%h st=%0d bus=%h want %h 3 04",
                     seq, init_state, internal_data_bus, exp_seq);
        end
        do_write(1'b1, 8'h01, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW4, S_NONE};
        checks++;
        if (seq !== exp_seq || init_state !== 3'd4 || internal_data_bus !== 8'h01 ||
            {done_at[2], done_at[3]} !== 2'b01) begin
            errors++;
            $display("FAIL casc_icw4 got seq=%h st=%0d bus=%h done23=%b%b want %h 4 01 01",
                     seq, init_state, internal_data_bus, done_at[2], done_at[3], exp_seq);
        end
    endtask

    task automatic test_ocw();
        do_write(1'b1, 8'hFB, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_OCW1, S_NONE};
        checks++;
        if (seq !== exp_seq || internal_data_bus !== 8'hFB) begin
            errors++;
            $display("FAIL ocw1 got seq=%h bus=%h want %h FB", seq, internal_data_bus, exp_seq);
        end
        do_write(1'b0, 8'h20, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_OCW2, S_NONE};
        checks++;
        if (seq !== exp_seq || internal_data_bus !== 8'h20) begin
            errors++;
            $display("FAIL ocw2 got seq=%h bus=%h want %h 20", seq, internal_data_bus, exp_seq);
        end
        do_write(1'b0, 8'h0B, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_OCW3, S_NONE};
        checks++;
        if (seq !== exp_seq || internal_data_bus !== 8'h0B ||
            init_state !== 3'd4 || initialization_done !== 1'b1) begin
            errors++;
            $display("FAIL ocw3 got seq=%h bus=%h st=%0d done=%b want %h 0B 4 1",
                     seq, internal_data_bus, init_state, initialization_done, exp_seq);
        end
    endtask

    task automatic test_restart();
        do_write(1'b0, 8'h11, 1'b1);
        do_write(1'b1, 8'h20, 1'b1);
        checks++;
        if (init_state !== 3'd2) begin
            errors++;
            $display("FAIL restart_setup got st=%0d want 2", init_state);
        end
        do_write(1'b0, 8'h12, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW1, S_NONE};
        checks++;
        if (seq !== exp_seq || init_state !== 3'd1 ||
            initialization_done !== 1'b0 || internal_data_bus !== 8'h12) begin
            errors++;
            $display("FAIL restart_icw1 got seq=%h st=%0d done=%b bus=%h want %h 1 0 12",
                     seq, init_state, initialization_done, internal_data_bus, exp_seq);
        end
        do_write(1'b0, 8'h20, 1'b1);
        checks++;
        if (seq !== '0 || init_state !== 3'd1 || internal_data_bus !== 8'h12) begin
            errors++;
            $display("FAIL ignored_ocw got seq=%h st=%0d bus=%h want 0 1 12",
                     seq, init_state, internal_data_bus);
        end
    endtask

    task automatic test_no_chip_select();
        do_write(1'b1, 8'h55, 1'b0);
        checks++;
        if (seq !== '0 || init_state !== 3'd1 || internal_data_bus !== 8'h12) begin
            errors++;
            $display("FAIL no_cs got seq=%h st=%0d bus=%h want 0 1 12",
                     seq, init_state, internal_data_bus);
        end
        do_write(1'b1, 8'h33, 1'b1);
        exp_seq = {S_NONE, S_NONE, S_ICW2, S_NONE};
        checks++;
        if (seq !== exp_seq || init_state !== 3'd4 ||
            initialization_done !== 1'b1 || internal_data_bus !== 8'h33) begin
            errors++;
            $display("FAIL sngl_no_ic4 got seq=%h st=%0d done=%b bus=%h want %h 4 1 33",
                     seq, init_state, initialization_done, internal_data_bus, exp_seq);
        end
    endtask

    task automatic test_reset_pulse();
        do_write(1'b0, 8'h13, 1'b1);
        do_write(1'b1, 8'h40, 1'b1);
        checks++;
        if (init_state !== 3'd3) begin
            errors++;
            $display("FAIL pulse_setup got st=%0d want 3", init_state);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({stb, init_state, initialization_done, internal_data_bus}
            !== {S_NONE, 3'd0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_pulse got stb=%b st=%0d done=%b bus=%h want 0/0/0/00",
                     stb, init_state, initialization_done, internal_data_bus);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clock);
        reset              = 1'b1;
        bus.address        = 1'b0;
        bus.data_bus_in    = 8'h13;
        bus.chip_select_n  = 1'b0;
        bus.write_enable_n = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        release_watch();
        exp_seq = {S_NONE, S_NONE, S_ICW1, S_NONE};
        checks++;
        if (seq !== exp_seq || init_state !== 3'd1 || internal_data_bus !== 8'h13) begin
            errors++;
            $display("FAIL reset_mid_write got seq=%h st=%0d bus=%h want %h 1 13",
                     seq, init_state, internal_data_bus, exp_seq);
        end
    endtask

    task automatic test_reset_on_accept();
        drive_low(1'b1, 8'h40, 1'b1);
        bus.write_enable_n = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        seen[3] = stb;
        @(negedge clock);
        reset             = 1'b0;
        bus.chip_select_n = 1'b1;
        @(posedge clock);
        #1;
        seen[4] = stb;
        checks++;
        if ({seen[3], seen[4]} !== '0 || init_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_on_accept got s3=%b s4=%b st=%0d want 0 0 0",
                     seen[3], seen[4], init_state);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.chip_select_n  = 1'b1;
        bus.write_enable_n = 1'b1;
        bus.address        = 1'b0;
        bus.data_bus_in    = 8'h00;
        test_reset();
        test_single_icw4();
        test_cascade();
        test_ocw();
        test_restart();
        test_no_chip_select();
        test_reset_pulse();
        test_reset_mid_write();
        test_reset_on_accept();
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
